// File: rtl/rx_port_arb_pkg.sv
// rx_port_arb_pkg: shared FSM encoding, defaults and port indices for rx_port_arb.
package rx_port_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, DROP = 2'd3} state_e;
  localparam int MAX_WORDS_DEF = 768;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {14'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/rx_port_arb_if.sv
// rx_port_arb_if: two input packet ports plus the merged output port.
interface rx_port_arb_if;
  logic [15:0] in0_data, in1_data, dout;
  logic in0_sop, in0_eop, in0_vld, in0_mod, in0_rdy;
  logic in1_sop, in1_eop, in1_vld, in1_mod, in1_rdy;
  logic dout_sop, dout_eop, dout_vld, dout_mod, dout_err, dout_rdy;
  modport master (
    output in0_data, in0_sop, in0_eop, in0_vld, in0_mod,
    output in1_data, in1_sop, in1_eop, in1_vld, in1_mod,
    input  in0_rdy, in1_rdy,
    input  dout, dout_sop, dout_eop, dout_vld, dout_mod, dout_err,
    output dout_rdy
  );
  modport slave (
    input  in0_data, in0_sop, in0_eop, in0_vld, in0_mod,
    input  in1_data, in1_sop, in1_eop, in1_vld, in1_mod,
    output in0_rdy, in1_rdy,
    output dout, dout_sop, dout_eop, dout_vld, dout_mod, dout_err,
    input  dout_rdy
  );
endinterface

// File: rtl/rx_port_arb_oreg.sv
// rx_port_arb_oreg: registered output stage; loads on load_en, holds while stalled.
module rx_port_arb_oreg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en_i,
  input  logic        ld_i,
  input  logic [15:0] data_i,
  input  logic        sop_i,
  input  logic        eop_i,
  input  logic        mod_i,
  input  logic        err_i,
  output logic [15:0] data_o,
  output logic        sop_o,
  output logic        eop_o,
  output logic        mod_o,
  output logic        err_o,
  output logic        vld_o
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_o <= '0;
      sop_o  <= 1'b0;
      eop_o  <= 1'b0;
      mod_o  <= 1'b0;
      err_o  <= 1'b0;
      vld_o  <= 1'b0;
    end else if (load_en_i) begin
      vld_o <= ld_i;
      if (ld_i) begin
        data_o <= data_i;
        sop_o  <= sop_i;
        eop_o  <= eop_i;
        mod_o  <= mod_i;
        err_o  <= err_i;
      end
    end
endmodule

// File: rtl/rx_port_arb.sv
// rx_port_arb: two-port packet arbiter with round-robin grant, watchdog abort and orphan drain.
// Optional statistics counters are enabled with RX_PORT_ARB_STATS_EN.
module rx_port_arb
  import rx_port_arb_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  rx_port_arb_if.slave bus
`ifdef RX_PORT_ARB_STATS_EN
  ,
  output logic [15:0] pkt_cnt0,
  output logic [15:0] pkt_cnt1,
  output logic [15:0] err_cnt
`endif
);
  state_e      state_q;
  logic        sel_q, rr_q;
  logic [15:0] cnt_q;
  logic [15:0] data, o_data;
  logic        sop, eop, vld, mod;
  logic        o_sop, o_eop, o_mod, o_err, o_vld;
  logic        load_en, gnt, acc, last, abort_w, orph0, orph1, start0, start1, pick1;
  assign data    = sel_q ? bus.in1_data : bus.in0_data;
  assign sop     = sel_q ? bus.in1_sop  : bus.in0_sop;
  assign eop     = sel_q ? bus.in1_eop  : bus.in0_eop;
  assign vld     = sel_q ? bus.in1_vld  : bus.in0_vld;
  assign mod     = sel_q ? bus.in1_mod  : bus.in0_mod;
  assign load_en = bus.dout_rdy || !o_vld;
  assign gnt     = state_q == GNT0 || state_q == GNT1;
  assign acc     = gnt && vld && load_en;
  assign last    = cnt_q + 16'd1 == 16'(MAX_WORDS);
  assign abort_w = !eop && last;
  // rdy is held low during reset so nothing is drained before the block is live
  assign orph0   = rst_n && state_q == IDLE && bus.in0_vld && !bus.in0_sop;
  assign orph1   = rst_n && state_q == IDLE && bus.in1_vld && !bus.in1_sop;
  assign start0  = bus.in0_vld && bus.in0_sop;
  assign start1  = bus.in1_vld && bus.in1_sop;
  assign pick1   = start1 && (!start0 || rr_q);
  assign bus.in0_rdy = orph0 || (state_q == GNT0 && load_en) || (state_q == DROP && sel_q == PORT0);
  assign bus.in1_rdy = orph1 || (state_q == GNT1 && load_en) || (state_q == DROP && sel_q == PORT1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= PORT0;
      rr_q    <= PORT0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (start0 || start1) begin
            state_q <= pick1 ? GNT1 : GNT0;
            sel_q   <= pick1 ? PORT1 : PORT0;
            cnt_q   <= '0;
          end
        GNT0, GNT1:
          if (acc) begin
            cnt_q <= cnt_q + 16'd1;
            if (eop) begin
              state_q <= IDLE;
              rr_q    <= ~sel_q;
            end else if (last) state_q <= DROP;
          end
        DROP:
          if (vld && eop) begin
            state_q <= IDLE;
            rr_q    <= ~sel_q;
          end
        default: state_q <= IDLE;
      endcase
    end
  rx_port_arb_oreg u_oreg (
    .clk(clk), .rst_n(rst_n), .load_en_i(load_en), .ld_i(acc),
    .data_i(data), .sop_i(sop && cnt_q == 16'd0), .eop_i(eop || abort_w),
    .mod_i(eop && mod), .err_i(abort_w),
    .data_o(o_data), .sop_o(o_sop), .eop_o(o_eop), .mod_o(o_mod), .err_o(o_err), .vld_o(o_vld)
  );
  assign bus.dout     = o_data;
  assign bus.dout_sop = o_sop;
  assign bus.dout_eop = o_eop;
  assign bus.dout_mod = o_mod;
  assign bus.dout_err = o_err;
  assign bus.dout_vld = o_vld;
`ifdef RX_PORT_ARB_STATS_EN
  logic fwd_eop, mid_sop;
  assign fwd_eop = acc && (eop || last);
  assign mid_sop = acc && sop && cnt_q != 16'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
      err_cnt  <= '0;
    end else begin
      pkt_cnt0 <= sat_add(pkt_cnt0, {2'b0, fwd_eop && sel_q == PORT0});
      pkt_cnt1 <= sat_add(pkt_cnt1, {2'b0, fwd_eop && sel_q == PORT1});
      err_cnt  <= sat_add(err_cnt, 3'(acc && abort_w) + 3'(mid_sop) + 3'(orph0) + 3'(orph1));
    end
`endif
endmodule

// File: tb/tb_rx_port_arb.sv
// tb_rx_port_arb: directed self-checking bench for rx_port_arb (MAX_WORDS=8).
module tb_rx_port_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  bit tog = 1'b0;
  logic [15:0] obs_d[$];
  logic [3:0]  obs_f[$];
  rx_port_arb_if bus();
`ifdef RX_PORT_ARB_STATS_EN
  logic [15:0] pkt_cnt0, pkt_cnt1, err_cnt;
`endif
  rx_port_arb #(.MAX_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef RX_PORT_ARB_STATS_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .err_cnt(err_cnt)
`endif
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.dout_vld && bus.dout_rdy) begin
      obs_d.push_back(bus.dout);
      obs_f.push_back({bus.dout_sop, bus.dout_eop, bus.dout_mod, bus.dout_err});
    end
    if (tog && bus.dout_vld && !bus.dout_rdy) check("t37_stall_rdy", {31'b0, bus.in0_rdy}, 32'd0);
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (tog) bus.dout_rdy = ~bus.dout_rdy;
  end

  task automatic drive(input bit p, input logic [15:0] d, input bit s, input bit e, input bit m);
    bit ok = 1'b0;
    if (p) begin
      bus.in1_data = d; bus.in1_sop = s; bus.in1_eop = e; bus.in1_mod = m; bus.in1_vld = 1'b1;
    end else begin
      bus.in0_data = d; bus.in0_sop = s; bus.in0_eop = e; bus.in0_mod = m; bus.in0_vld = 1'b1;
    end
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = p ? bus.in1_rdy : bus.in0_rdy;
    end
    if (!ok) check("drive_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (p) bus.in1_vld = 1'b0; else bus.in0_vld = 1'b0;
  endtask

  task automatic send(input bit p, input logic [15:0] base, input int n, input bit sop1, input bit eopn, input bit modn);
    for (int i = 0; i < n; i++)
      drive(p, 16'(base + 16'(i)), sop1 && i == 0, eopn && i == n - 1, modn && i == n - 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in0_vld = 1'b0; bus.in1_vld = 1'b0;
    bus.dout_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in0_data = '0; bus.in0_sop = 0; bus.in0_eop = 0; bus.in0_mod = 0; bus.in0_vld = 0;
    bus.in1_data = '0; bus.in1_sop = 0; bus.in1_eop = 0; bus.in1_mod = 0; bus.in1_vld = 0;
    bus.dout_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // reset state, with an orphan word presented during reset
    bus.in0_vld = 1'b1;
    #1;
    check("rst_in0_rdy", {31'b0, bus.in0_rdy}, 32'd0);
    check("rst_in1_rdy", {31'b0, bus.in1_rdy}, 32'd0);
    check("rst_dout", {16'b0, bus.dout}, 32'd0);
    check("rst_vld", {31'b0, bus.dout_vld}, 32'd0);
    check("rst_flags", {28'b0, bus.dout_sop, bus.dout_eop, bus.dout_mod, bus.dout_err}, 32'd0);
    bus.in0_vld = 1'b0;
    do_reset();
    // single 4-word packet on port 0
    obs_d.delete(); obs_f.delete();
    drive(0, 16'hA000, 1, 0, 0);
    check("t35_lat_vld", {31'b0, bus.dout_vld}, 32'd1);
    check("t35_lat_dat", {16'b0, bus.dout}, 32'h0000A000);
    send(0, 16'hA001, 3, 0, 1, 1);
    settle();
    check("t35_n", obs_d.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t35_d%0d", i), {16'b0, obs_d[i]}, 32'hA000 + i);
      check($sformatf("t35_f%0d", i), {28'b0, obs_f[i]}, i == 0 ? 32'h8 : i == 3 ? 32'h6 : 32'h0);
    end
`ifdef RX_PORT_ARB_STATS_EN
    check("t35_pkt0", {16'b0, pkt_cnt0}, 32'd1);
    check("t35_err", {16'b0, err_cnt}, 32'd0);
`endif
    // simultaneous sop after reset: port 0 first, then port 1
    do_reset();
    obs_d.delete(); obs_f.delete();
    fork
      send(0, 16'hB000, 2, 1, 1, 0);
      send(1, 16'hC000, 2, 1, 1, 0);
    join
    settle();
    check("t36_n", obs_d.size(), 32'd4);
    check("t36_d0", {16'b0, obs_d[0]}, 32'hB000);
    check("t36_d1", {16'b0, obs_d[1]}, 32'hB001);
    check("t36_d2", {16'b0, obs_d[2]}, 32'hC000);
    check("t36_d3", {16'b0, obs_d[3]}, 32'hC001);
    check("t36_f0", {28'b0, obs_f[0]}, 32'h8);
    check("t36_f3", {28'b0, obs_f[3]}, 32'h4);
`ifdef RX_PORT_ARB_STATS_EN
    check("t36_pkt0", {16'b0, pkt_cnt0}, 32'd1);
    check("t36_pkt1", {16'b0, pkt_cnt1}, 32'd1);
`endif
    // backpressure toggling every cycle during a 6-word packet
    obs_d.delete(); obs_f.delete();
    tog = 1'b1;
    send(0, 16'hD000, 6, 1, 1, 0);
    repeat (6) @(posedge clk);
    #1;
    tog = 1'b0;
    bus.dout_rdy = 1'b1;
    settle();
    check("t37_n", obs_d.size(), 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("t37_d%0d", i), {16'b0, obs_d[i]}, 32'hD000 + i);
    check("t37_f5", {28'b0, obs_f[5]}, 32'h4);
    // watchdog abort: 12 words with MAX_WORDS=8
    do_reset();
    obs_d.delete(); obs_f.delete();
    send(1, 16'hE000, 12, 1, 1, 0);
    settle();
    check("t38_n", obs_d.size(), 32'd8);
    check("t38_d7", {16'b0, obs_d[7]}, 32'hE007);
    check("t38_f0", {28'b0, obs_f[0]}, 32'h8);
    check("t38_f6", {28'b0, obs_f[6]}, 32'h0);
    check("t38_f7", {28'b0, obs_f[7]}, 32'h5);
`ifdef RX_PORT_ARB_STATS_EN
    check("t38_err", {16'b0, err_cnt}, 32'd1);
`endif
    send(0, 16'h1000, 1, 1, 1, 0);
    settle();
    check("t38_after_n", obs_d.size(), 32'd9);
    check("t38_after_f", {28'b0, obs_f[8]}, 32'hC);
    // orphan words on port 1 while idle
    do_reset();
    obs_d.delete(); obs_f.delete();
    bus.in1_sop = 1'b0; bus.in1_vld = 1'b1;
    #1;
    check("t39_rdy", {31'b0, bus.in1_rdy}, 32'd1);
    send(1, 16'h2000, 3, 0, 0, 0);
    settle();
    check("t39_n", obs_d.size(), 32'd0);
`ifdef RX_PORT_ARB_STATS_EN
    check("t39_err", {16'b0, err_cnt}, 32'd3);
`endif
    // reset mid-packet at word 3 of 5
    do_reset();
    obs_d.delete(); obs_f.delete();
    send(0, 16'hF000, 3, 1, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("t40_dout", {16'b0, bus.dout}, 32'd0);
    check("t40_vld", {31'b0, bus.dout_vld}, 32'd0);
    check("t40_rdy", {30'b0, bus.in0_rdy, bus.in1_rdy}, 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0, 16'hF003, 2, 0, 1, 0);
    send(0, 16'h9000, 2, 1, 1, 0);
    settle();
    check("t40_n", obs_d.size(), 32'd4);
    check("t40_d1", {16'b0, obs_d[1]}, 32'hF001);
    check("t40_f1", {28'b0, obs_f[1]}, 32'h0);
    check("t40_d2", {16'b0, obs_d[2]}, 32'h9000);
    check("t40_f2", {28'b0, obs_f[2]}, 32'h8);
    check("t40_f3", {28'b0, obs_f[3]}, 32'h4);
`ifdef RX_PORT_ARB_STATS_EN
    check("t40_err", {16'b0, err_cnt}, 32'd2);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
